// File: rtl/token_encoder_pkg.sv
// Shared state encoding, NUL constant and ASCII case-folding helper for the token encoder.
package token_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE, WSTART, REQ, CHK, SKIPV, SKIPW, EMIT, FINISH
  } state_t;

  // Characters are widened to this width before folding so one helper serves any DATA_WIDTH.
  localparam int CHAR_MAX_W = 32;
  localparam logic [CHAR_MAX_W-1:0] NUL = '0;

  function automatic logic [CHAR_MAX_W-1:0] fold_char(input logic [CHAR_MAX_W-1:0] c,
                                                      input logic en);
    logic [CHAR_MAX_W-1:0] r;
    r = c;
    if (en && (c >= 32'd65) && (c <= 32'd90)) r = c + 32'd32;
    return r;
  endfunction

endpackage

// File: rtl/char_cmp.sv
// Combinational character comparator with optional ASCII case folding.
// Latency: 0 cycles; no backpressure (pure logic).
module char_cmp import token_encoder_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int CASE_FOLD  = 0
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_eq,
  output logic                  o_both_zero
);

  logic [CHAR_MAX_W-1:0] w_a;
  logic [CHAR_MAX_W-1:0] w_b;

  assign w_a         = fold_char(CHAR_MAX_W'(i_a), CASE_FOLD != 0);
  assign w_b         = fold_char(CHAR_MAX_W'(i_b), CASE_FOLD != 0);
  assign o_eq        = (w_a == w_b);
  assign o_both_zero = (w_a == NUL) && (w_b == NUL);

endmodule

// File: rtl/token_encoder.sv
// Maps each NUL-delimited input word to its vocabulary ordinal (or UNK_ID) and writes it out.
// Latency: 2 cycles per compared char, 1-cycle emit; no backpressure, start ignored while busy.
module token_encoder import token_encoder_pkg::*; #(
  parameter int DATA_WIDTH     = 8,
  parameter int IN_ADDR_WIDTH  = 8,
  parameter int VOC_ADDR_WIDTH = 10,
  parameter int OUT_ADDR_WIDTH = 6,
  parameter int TOK_WIDTH      = 8,
  parameter int UNK_ID         = 2**TOK_WIDTH - 1,
  parameter int CASE_FOLD      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow,
  output logic [OUT_ADDR_WIDTH:0]   o_token_count,
  output logic [IN_ADDR_WIDTH-1:0]  o_in_addr,
  input  logic [DATA_WIDTH-1:0]     i_in_data,
  output logic [VOC_ADDR_WIDTH-1:0] o_voc_addr,
  input  logic [DATA_WIDTH-1:0]     i_voc_data,
  output logic                      o_out_we,
  output logic [OUT_ADDR_WIDTH-1:0] o_out_addr,
  output logic [TOK_WIDTH-1:0]      o_out_data
);

  // Pointers carry spare high bits so a read past the end of either memory is detectable.
  localparam int PW = ((IN_ADDR_WIDTH > VOC_ADDR_WIDTH) ? IN_ADDR_WIDTH : VOC_ADDR_WIDTH) + 2;
  localparam logic [OUT_ADDR_WIDTH:0] CAP = {1'b1, {OUT_ADDR_WIDTH{1'b0}}};
  localparam logic [TOK_WIDTH-1:0]    UNK = TOK_WIDTH'(UNK_ID);

  state_t                      r_state;
  logic [PW-1:0]               r_wp, r_vp, r_k, r_a, r_wp_next;
  logic [TOK_WIDTH-1:0]        r_tok, r_id, r_out_data;
  logic [OUT_ADDR_WIDTH:0]     r_op;
  logic [OUT_ADDR_WIDTH-1:0]   r_out_addr;
  logic [IN_ADDR_WIDTH-1:0]    r_in_addr;
  logic [VOC_ADDR_WIDTH-1:0]   r_voc_addr;
  logic                        r_ph, r_busy, r_done, r_ovf, r_out_we;

  logic [PW-1:0] w_in_inc, w_voc_inc, w_a_inc;
  logic          w_wp_bad, w_in_inc_bad, w_voc_inc_bad, w_a_in_bad, w_a_voc_bad;
  logic          w_eq, w_both_zero, w_in_zero, w_voc_zero, w_voc_end;

  char_cmp #(.DATA_WIDTH(DATA_WIDTH), .CASE_FOLD(CASE_FOLD)) u_cmp (
    .i_a        (i_in_data),
    .i_b        (i_voc_data),
    .o_eq       (w_eq),
    .o_both_zero(w_both_zero)
  );

  assign w_in_inc      = r_wp + r_k + PW'(1);
  assign w_voc_inc     = r_vp + r_k + PW'(1);
  assign w_a_inc       = r_a + PW'(1);
  assign w_wp_bad      = |(r_wp >> IN_ADDR_WIDTH);
  assign w_in_inc_bad  = |(w_in_inc >> IN_ADDR_WIDTH);
  assign w_voc_inc_bad = |(w_voc_inc >> VOC_ADDR_WIDTH);
  assign w_a_in_bad    = |(w_a_inc >> IN_ADDR_WIDTH);
  assign w_a_voc_bad   = |(w_a_inc >> VOC_ADDR_WIDTH);
  assign w_in_zero     = (i_in_data == '0);
  assign w_voc_zero    = (i_voc_data == '0);
  assign w_voc_end     = w_voc_zero || (r_tok >= UNK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wp <= '0; r_vp <= '0; r_k <= '0; r_a <= '0; r_wp_next <= '0;
      r_tok <= '0; r_id <= '0; r_op <= '0; r_ph <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0; r_ovf <= 1'b0; r_out_we <= 1'b0;
      r_out_addr <= '0; r_out_data <= '0; r_in_addr <= '0; r_voc_addr <= '0;
    end else begin
      r_out_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_busy <= 1'b1; r_ovf <= 1'b0; r_op <= '0; r_wp <= '0;
          r_state <= WSTART;
        end
        WSTART: begin
          r_vp <= '0; r_tok <= '0; r_k <= '0;
          if (w_wp_bad) begin r_ovf <= 1'b1; r_state <= FINISH; end
          else begin
            r_in_addr <= r_wp[IN_ADDR_WIDTH-1:0]; r_voc_addr <= '0; r_state <= REQ;
          end
        end
        REQ: r_state <= CHK;
        CHK: begin
          if (r_k == '0 && w_in_zero) r_state <= FINISH;
          else if (r_k == '0 && w_voc_end) begin
            r_id <= UNK; r_a <= r_wp; r_in_addr <= r_wp[IN_ADDR_WIDTH-1:0];
            r_ph <= 1'b0; r_state <= SKIPW;
          end else if (w_both_zero) begin
            r_id <= r_tok; r_wp_next <= w_in_inc; r_state <= EMIT;
          end else if (w_eq) begin
            if (w_in_inc_bad || w_voc_inc_bad) begin r_ovf <= 1'b1; r_state <= FINISH; end
            else begin
              r_k <= r_k + PW'(1);
              r_in_addr <= w_in_inc[IN_ADDR_WIDTH-1:0];
              r_voc_addr <= w_voc_inc[VOC_ADDR_WIDTH-1:0];
              r_state <= REQ;
            end
          end else if (w_voc_inc_bad) begin r_ovf <= 1'b1; r_state <= FINISH; end
          else if (w_voc_zero) begin
            // Entry was a proper prefix of the word: restart on the next entry.
            r_vp <= w_voc_inc; r_k <= '0; r_tok <= r_tok + 1'b1;
            r_in_addr <= r_wp[IN_ADDR_WIDTH-1:0];
            r_voc_addr <= w_voc_inc[VOC_ADDR_WIDTH-1:0];
            r_state <= REQ;
          end else begin
            r_a <= w_voc_inc; r_voc_addr <= w_voc_inc[VOC_ADDR_WIDTH-1:0];
            r_ph <= 1'b0; r_state <= SKIPV;
          end
        end
        SKIPV: begin
          if (!r_ph) r_ph <= 1'b1;
          else if (w_a_voc_bad) begin r_ovf <= 1'b1; r_state <= FINISH; end
          else if (w_voc_zero) begin
            r_vp <= w_a_inc; r_tok <= r_tok + 1'b1; r_k <= '0;
            r_in_addr <= r_wp[IN_ADDR_WIDTH-1:0];
            r_voc_addr <= w_a_inc[VOC_ADDR_WIDTH-1:0];
            r_state <= REQ;
          end else begin
            r_a <= w_a_inc; r_voc_addr <= w_a_inc[VOC_ADDR_WIDTH-1:0]; r_ph <= 1'b0;
          end
        end
        SKIPW: begin
          if (!r_ph) r_ph <= 1'b1;
          else if (w_in_zero) begin r_wp_next <= w_a_inc; r_state <= EMIT; end
          else if (w_a_in_bad) begin r_ovf <= 1'b1; r_state <= FINISH; end
          else begin
            r_a <= w_a_inc; r_in_addr <= w_a_inc[IN_ADDR_WIDTH-1:0]; r_ph <= 1'b0;
          end
        end
        EMIT: begin
          if (r_op == CAP) begin r_ovf <= 1'b1; r_state <= FINISH; end
          else begin
            r_out_we <= 1'b1; r_out_addr <= r_op[OUT_ADDR_WIDTH-1:0]; r_out_data <= r_id;
            r_op <= r_op + 1'b1; r_wp <= r_wp_next; r_state <= WSTART;
          end
        end
        FINISH: begin
          r_done <= 1'b1; r_busy <= 1'b0; r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A write pending from the previous cycle is suppressed if reset lands on it.
  assign o_out_we      = r_out_we & ~rst;
  assign o_out_addr    = r_out_addr;
  assign o_out_data    = r_out_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_overflow    = r_ovf;
  assign o_token_count = r_op;
  assign o_in_addr     = r_in_addr;
  assign o_voc_addr    = r_voc_addr;

endmodule

// File: tb/tb_token_encoder.sv
// Bench for token_encoder: directed cases plus random vocab/input checked against a string-level model.
module tb_token_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0] in_mem  [0:255];
  logic [7:0] voc_mem [0:1023];

  // Instance A: default parameters.
  logic       a_start, a_busy, a_done, a_ovf, a_we;
  logic [6:0] a_cnt;
  logic [7:0] a_in_addr, a_in_data, a_voc_data, a_out_data;
  logic [9:0] a_voc_addr;
  logic [5:0] a_out_addr;
  // Instance B: two-entry output, 2-bit IDs (UNK=3), case folding on.
  logic       b_start, b_busy, b_done, b_ovf, b_we;
  logic [1:0] b_cnt, b_out_data;
  logic [7:0] b_in_addr, b_in_data, b_voc_data;
  logic [9:0] b_voc_addr;
  logic [0:0] b_out_addr;

  token_encoder u_a (
    .clk(clk), .rst(rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
    .o_overflow(a_ovf), .o_token_count(a_cnt), .o_in_addr(a_in_addr), .i_in_data(a_in_data),
    .o_voc_addr(a_voc_addr), .i_voc_data(a_voc_data), .o_out_we(a_we),
    .o_out_addr(a_out_addr), .o_out_data(a_out_data));

  token_encoder #(.OUT_ADDR_WIDTH(1), .TOK_WIDTH(2), .CASE_FOLD(1)) u_b (
    .clk(clk), .rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
    .o_overflow(b_ovf), .o_token_count(b_cnt), .o_in_addr(b_in_addr), .i_in_data(b_in_data),
    .o_voc_addr(b_voc_addr), .i_voc_data(b_voc_data), .o_out_we(b_we),
    .o_out_addr(b_out_addr), .o_out_data(b_out_data));

  always @(posedge clk) begin
    a_in_data  <= in_mem[a_in_addr];
    a_voc_data <= voc_mem[a_voc_addr];
    b_in_data  <= in_mem[b_in_addr];
    b_voc_data <= voc_mem[b_voc_addr];
  end

  int a_wr_addr[$], a_wr_dat[$], b_wr_addr[$], b_wr_dat[$];
  int a_dn = 0, b_dn = 0;
  always @(negedge clk) begin
    if (a_we) begin a_wr_addr.push_back(int'(a_out_addr)); a_wr_dat.push_back(int'(a_out_data)); end
    if (b_we) begin b_wr_addr.push_back(int'(b_out_addr)); b_wr_dat.push_back(int'(b_out_data)); end
    if (a_done) a_dn++;
    if (b_done) b_dn++;
  end

  int errors = 0, checks = 0;
  int exp_ids[$];
  bit exp_ovf;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // '/' in the strings stands for the NUL separator; a trailing NUL terminates each list.
  task automatic load(input string voc_s, input string in_s);
    foreach (in_mem[i]) in_mem[i] = 8'h00;
    foreach (voc_mem[i]) voc_mem[i] = 8'h00;
    for (int i = 0; i < in_s.len(); i++) in_mem[i] = (in_s[i] == "/") ? 8'h00 : in_s[i];
    for (int i = 0; i < voc_s.len(); i++) voc_mem[i] = (voc_s[i] == "/") ? 8'h00 : voc_s[i];
  endtask

  function automatic bit same(input string x, input string y, input bit fold);
    return fold ? (x.tolower() == y.tolower()) : (x == y);
  endfunction

  task automatic model(input bit fold, input int cap, input int unk);
    string voc[$];
    string w;
    int id;
    exp_ids.delete();
    exp_ovf = 0;
    w = "";
    for (int a = 0; a < 1024; a++) begin
      if (voc_mem[a] == 8'h00) begin
        if (w.len() == 0) break;
        voc.push_back(w); w = "";
      end else w = $sformatf("%s%c", w, voc_mem[a]);
    end
    w = "";
    for (int a = 0; a < 256; a++) begin
      if (in_mem[a] == 8'h00) begin
        if (w.len() == 0) break;
        if (exp_ids.size() == cap) begin exp_ovf = 1; break; end
        id = unk;
        for (int j = 0; j < voc.size() && j < unk; j++)
          if (same(voc[j], w, fold)) begin id = j; break; end
        exp_ids.push_back(id);
        w = "";
      end else w = $sformatf("%s%c", w, in_mem[a]);
    end
  endtask

  function automatic string rnd_word();
    string letters = "abAB";
    string w = "";
    int len = int'($urandom_range(3, 1));
    for (int i = 0; i < len; i++) w = $sformatf("%s%c", w, letters[$urandom_range(3, 0)]);
    return w;
  endfunction

  task automatic gen(input int nvoc, input int nw);
    string v[$];
    string voc_s = "", in_s = "", w;
    for (int i = 0; i < nvoc; i++) begin w = rnd_word(); v.push_back(w); voc_s = {voc_s, w, "/"}; end
    for (int i = 0; i < nw; i++) begin
      case ($urandom_range(3, 0))
        0, 1:    w = v[$urandom_range(nvoc - 1, 0)];
        2:       w = rnd_word();
        default: w = {v[$urandom_range(nvoc - 1, 0)], rnd_word()};
      endcase
      in_s = {in_s, w, "/"};
    end
    load(voc_s, in_s);
  endtask

  task automatic run(input int sel, input string tag);
    int base_n, base_d, n, budget;
    base_n = sel ? b_wr_addr.size() : a_wr_addr.size();
    base_d = sel ? b_dn : a_dn;
    @(negedge clk);
    if (sel != 0) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
    chk({tag, " busy_after_start"}, sel ? b_busy : a_busy, 1);
    budget = 0;
    while (!(sel ? b_done : a_done) && budget < 20000) begin @(negedge clk); budget++; end
    chk({tag, " done_within_budget"}, int'(budget < 20000), 1);
    repeat (2) @(negedge clk);
    chk({tag, " done_pulses"}, (sel ? b_dn : a_dn) - base_d, 1);
    n = (sel ? b_wr_addr.size() : a_wr_addr.size()) - base_n;
    chk({tag, " writes"}, n, exp_ids.size());
    for (int i = 0; i < n && i < exp_ids.size(); i++) begin
      if (sel != 0) begin
        chk({tag, " out_addr"}, b_wr_addr[base_n + i], i);
        chk({tag, " out_data"}, b_wr_dat[base_n + i], exp_ids[i]);
      end else begin
        chk({tag, " out_addr"}, a_wr_addr[base_n + i], i);
        chk({tag, " out_data"}, a_wr_dat[base_n + i], exp_ids[i]);
      end
    end
    chk({tag, " token_count"}, sel ? int'(b_cnt) : int'(a_cnt), exp_ids.size());
    chk({tag, " overflow"}, sel ? b_ovf : a_ovf, int'(exp_ovf));
    chk({tag, " busy_idle"}, sel ? b_busy : a_busy, 0);
  endtask

  initial begin
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    load("", "");
    repeat (3) @(negedge clk);
    chk("rst a_busy", a_busy, 0);
    chk("rst a_done", a_done, 0);
    chk("rst a_we", a_we, 0);
    chk("rst a_ovf", a_ovf, 0);
    chk("rst a_cnt", a_cnt, 0);
    chk("rst a_in_addr", a_in_addr, 0);
    chk("rst a_voc_addr", a_voc_addr, 0);
    chk("rst a_out_addr", a_out_addr, 0);
    chk("rst b_busy", b_busy, 0);
    chk("rst b_cnt", b_cnt, 0);
    rst = 1'b0;

    load("hi/to/", "to/hi/");  exp_ids = '{1, 0};     exp_ovf = 0; run(0, "basic");
    load("hi/to/", "ok/hit/"); exp_ids = '{255, 255}; exp_ovf = 0; run(0, "unknown");
    load("hi/to/", "");        exp_ids.delete();      exp_ovf = 0; run(0, "empty");
    load("Hi/", "hI/");        exp_ids = '{255};      exp_ovf = 0; run(0, "nofold");
    exp_ids = '{0};            exp_ovf = 0; run(1, "fold");
    load("a/", "a/a/a/");      exp_ids = '{0, 0};     exp_ovf = 1; run(1, "outfull");
    load("a/b/c/d/e/", "e/c/"); exp_ids = '{3, 2};    exp_ovf = 0; run(1, "unk_ordinal");

    // Reset lands while the first character pair is being compared.
    load("hi/to/", "to/hi/");
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", a_busy, 0);
    chk("midrst we", a_we, 0);
    chk("midrst cnt", a_cnt, 0);
    chk("midrst done", a_done, 0);
    rst = 1'b0;
    exp_ids = '{1, 0}; exp_ovf = 0; run(0, "after_rst");

    for (int t = 0; t < 12; t++) begin
      gen(int'($urandom_range(6, 1)), int'($urandom_range(8, 0)));
      model(1'b0, 64, 255);
      run(0, "randA");
    end
    for (int t = 0; t < 8; t++) begin
      gen(int'($urandom_range(5, 1)), int'($urandom_range(3, 0)));
      model(1'b1, 2, 3);
      run(1, "randB");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
